// File: rtl/router_pkt_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_reader_pkg
//  Description : Shared router definitions: header field layout, packet
//                reader state encoding and the synchronizer read window.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkt_reader_pkg;

  // Header byte layout: [7:2] payload length, [1:0] destination address
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

  // Cycles a port may sit unread before the synchronizer fires soft_reset
  localparam int SOFT_RESET_WIN = 30;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    RD_HDR  = 3'd2,
    HDR_CAP = 3'd3,
    RD_BODY = 3'd4,
    DONE    = 3'd5
  } rd_state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

  function automatic logic [ADDR_MSB-ADDR_LSB:0] hdr_addr(input logic [7:0] hdr);
    return hdr[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_reader.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_reader
//  Description : Destination-side reader for one router output port. Pulls
//                header, payload and parity out of the port FIFO, strobes the
//                payload bytes, checks parity and reports completion or a
//                drop when the synchronizer's read window expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_reader
  import router_pkt_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DLY_W  = 5
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active low
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              soft_reset,
  input  logic [DLY_W-1:0]  start_delay,
  output logic              read_enb,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_data_valid,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              pkt_dropped,
  output logic              busy
);

  localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

  rd_state_t         state, state_nxt;
  logic [DLY_W-1:0]  dly_cnt;
  logic              rd_req, rd_req_nxt;
  logic              issued;       // a read was qualified last cycle; data_out is valid now
  logic [LEN_W:0]    rem_cnt, rem_nxt;  // bytes still to capture (payload + parity)
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] acc;
  logic              capture;
  logic              abort;

  // The request is registered; flow control and the window kill gate it live.
  assign read_enb = rd_req & vld_out & ~soft_reset;
  // A read issued last cycle is discarded if soft_reset arrives now.
  assign capture  = issued & ~soft_reset;
  // DONE is allowed to complete; everything else between IDLE and DONE drops.
  assign abort    = soft_reset && (state != IDLE) && (state != DONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vld_out && !soft_reset)
                 state_nxt = (start_delay == '0) ? RD_HDR : WAIT;
      WAIT:    if (dly_cnt <= DLY_W'(1)) state_nxt = RD_HDR;
      RD_HDR:  if (read_enb) state_nxt = HDR_CAP;
      HDR_CAP: state_nxt = RD_BODY;
      RD_BODY: if (capture && rem_cnt == REM_ONE) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Remaining-byte count: loaded from the header, stepped down on each capture
  always_comb begin
    rem_nxt = rem_cnt;
    if (state == HDR_CAP)
      rem_nxt = {1'b0, hdr_len(data_out[7:0])} + REM_ONE;
    else if (state == RD_BODY && capture)
      rem_nxt = rem_cnt - REM_ONE;
    if (abort) rem_nxt = '0;
  end

  // Outputs decoded from state, plus the next read request. A read issued this
  // cycle is still in flight, so it counts against the remaining bytes.
  always_comb begin
    busy       = (state != IDLE);
    pkt_done   = (state == DONE);
    rd_req_nxt = 1'b0;
    case (state_nxt)
      RD_HDR:  rd_req_nxt = 1'b1;
      RD_BODY: rd_req_nxt = read_enb ? (rem_nxt > REM_ONE) : (rem_nxt != '0);
      default: rd_req_nxt = 1'b0;
    endcase
  end

  // Datapath: delay counter, capture pipeline, parity accumulator and reports
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_cnt        <= '0;
      rd_req         <= 1'b0;
      issued         <= 1'b0;
      rem_cnt        <= '0;
      len_q          <= '0;
      acc            <= '0;
      pkt_data       <= '0;
      pkt_data_valid <= 1'b0;
      pkt_len        <= '0;
      parity_err     <= 1'b0;
      pkt_dropped    <= 1'b0;
    end else begin
      rd_req         <= rd_req_nxt;
      issued         <= read_enb;
      rem_cnt        <= rem_nxt;
      pkt_data_valid <= 1'b0;
      pkt_dropped    <= abort;

      if (state == IDLE && state_nxt == WAIT) dly_cnt <= start_delay;
      else if (state == WAIT)                 dly_cnt <= dly_cnt - DLY_W'(1);

      if (abort) begin
        dly_cnt <= '0;
        acc     <= '0;
        len_q   <= '0;
      end else if (state == HDR_CAP && capture) begin
        acc   <= data_out;
        len_q <= hdr_len(data_out[7:0]);
      end else if (state == RD_BODY && capture) begin
        if (rem_cnt > REM_ONE) begin
          pkt_data       <= data_out;
          pkt_data_valid <= 1'b1;
          acc            <= acc ^ data_out;
        end else begin
          pkt_len    <= len_q;
          parity_err <= (acc != data_out);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_pkt_reader
//  Description : Directed bench for router_pkt_reader with a FIFO model and a
//                synchronizer read-window model driving soft_reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_reader;
  import router_pkt_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vld_out;
  logic [7:0] data_out = 8'h00;
  logic       soft_reset = 1'b0;
  logic [4:0] start_delay = 5'd0;
  logic       read_enb;
  logic [7:0] pkt_data;
  logic       pkt_data_valid;
  logic [5:0] pkt_len;
  logic       pkt_done;
  logic       parity_err;
  logic       pkt_dropped;
  logic       busy;

  router_pkt_reader #(.DATA_W(8), .DLY_W(5)) dut (
    .clk(clk), .rst(rst), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .start_delay(start_delay), .read_enb(read_enb),
    .pkt_data(pkt_data), .pkt_data_valid(pkt_data_valid), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .parity_err(parity_err), .pkt_dropped(pkt_dropped),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on data_out the cycle after a qualified read
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  assign vld_out = (rd_ptr != wr_ptr) && !stall;

  always @(posedge clk) begin
    if (flush || soft_reset) rd_ptr <= wr_ptr;
    else if (read_enb) begin
      data_out <= mem[rd_ptr % 64];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Synchronizer model: soft_reset after SOFT_RESET_WIN unread cycles
  int unread = 0;
  always @(posedge clk) begin
    if (soft_reset) begin
      soft_reset <= 1'b0;
      unread     <= 0;
    end else if (vld_out && !read_enb) begin
      if (unread == SOFT_RESET_WIN - 1) soft_reset <= 1'b1;
      unread <= unread + 1;
    end else begin
      unread <= 0;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rd, n_got, n_done, n_drop, n_stall_rd, rd_cyc0, rd_cyc1;
  int first_done_cyc, rd_after_done, rd_before_done;
  int last_len, last_perr;
  int stall_left = 0;
  int stall_armed = 0;
  int stall_byte = 0;
  logic [7:0] got [0:63];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  task automatic clear_mon();
    n_rd = 0; n_got = 0; n_done = 0; n_drop = 0; n_stall_rd = 0;
    rd_cyc0 = -1; rd_cyc1 = -1; first_done_cyc = -1; rd_after_done = -1;
    rd_before_done = 0; last_len = -1; last_perr = -1;
  endtask

  // Sample one cycle at the falling edge, then return just after the next rising edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (read_enb) begin
      if (n_rd == 0) rd_cyc0 = cyc;
      if (n_rd == 1) rd_cyc1 = cyc;
      if (stall) n_stall_rd++;
      if (n_done == 0) rd_before_done++;
      if (n_done >= 1 && rd_after_done < 0) rd_after_done = cyc;
      n_rd++;
    end
    if (pkt_data_valid && n_got < 64) begin
      got[n_got] = pkt_data;
      n_got++;
    end
    if (pkt_done) begin
      if (n_done == 0) first_done_cyc = cyc;
      n_done++;
      last_len  = int'(pkt_len);
      last_perr = int'(parity_err);
    end
    if (pkt_dropped) n_drop++;
    if (stall_armed != 0 && pkt_data_valid && int'(pkt_data) == stall_byte) begin
      stall_left  = 5;
      stall_armed = 0;
    end
    @(posedge clk);
    #1;
    stall = (stall_left != 0);
    if (stall_left != 0) stall_left--;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && n_done < target; i++) tick();
    check_eq("done_within_budget", n_done, target);
  endtask

  task automatic push_pkt1(input logic [7:0] par);
    push(8'h12); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(par);
  endtask

  initial begin
    clear_mon();
    // Reset state
    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_read_enb", read_enb, 0);
    check_eq("rst_pkt_done", pkt_done, 0);
    check_eq("rst_pkt_len", pkt_len, 0);
    check_eq("rst_parity_err", parity_err, 0);
    check_eq("rst_pkt_dropped", pkt_dropped, 0);
    rst = 1'b1;
    tick();

    // 1: good packet, L=4
    clear_mon();
    push_pkt1(8'h16);
    wait_done(1, 40);
    tick(); tick();
    check_eq("t1_reads", n_rd, 6);
    check_eq("t1_nbytes", n_got, 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t1_byte%0d", i), got[i], i + 1);
    check_eq("t1_len", last_len, 4);
    check_eq("t1_perr", last_perr, 0);
    check_eq("t1_hdr_gap", rd_cyc1 - rd_cyc0, 2);
    check_eq("t1_len_hold", pkt_len, 4);
    check_eq("t1_busy_after", busy, 0);

    // 2: bad parity
    clear_mon();
    push_pkt1(8'h17);
    wait_done(1, 40);
    tick();
    check_eq("t2_len", last_len, 4);
    check_eq("t2_perr", last_perr, 1);
    check_eq("t2_perr_hold", parity_err, 1);

    // 3: start delay outlasts the read window
    clear_mon();
    start_delay = 5'd31;
    push_pkt1(8'h16);
    for (int i = 0; i < 60 && n_drop == 0; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    check_eq("t3_reads", n_rd, 0);
    check_eq("t3_drops", n_drop, 1);
    check_eq("t3_done", n_done, 0);
    check_eq("t3_busy", busy, 0);
    start_delay = 5'd0;

    // 4: vld_out stall after payload byte 02
    clear_mon();
    stall_byte  = 8'h02;
    stall_armed = 1;
    push_pkt1(8'h16);
    wait_done(1, 60);
    tick();
    check_eq("t4_stall_reads", n_stall_rd, 0);
    check_eq("t4_reads", n_rd, 6);
    check_eq("t4_nbytes", n_got, 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t4_byte%0d", i), got[i], i + 1);
    check_eq("t4_perr", last_perr, 0);

    // 5: asynchronous reset in the body
    clear_mon();
    push_pkt1(8'h16);
    for (int i = 0; i < 40 && n_got < 2; i++) tick();
    check_eq("t5_busy_before", busy, 1);
    check_eq("t5_rd_before", read_enb, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_async_rd", read_enb, 0);
    check_eq("t5_async_busy", busy, 0);
    check_eq("t5_async_valid", pkt_data_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rst = 1'b1;
    tick();
    clear_mon();
    push(8'h01); push(8'h01);
    wait_done(1, 40);
    check_eq("t5_len", last_len, 0);
    check_eq("t5_perr", last_perr, 0);
    check_eq("t5_nbytes", n_got, 0);
    check_eq("t5_reads", n_rd, 2);

    // 6: L=0 packet followed back-to-back by an L=1 packet
    clear_mon();
    push(8'h01); push(8'h01);
    push(8'h05); push(8'hAA); push(8'hAF);
    wait_done(2, 40);
    tick();
    check_eq("t6_first_reads", rd_before_done, 2);
    check_eq("t6_restart_gap", rd_after_done - first_done_cyc, 2);
    check_eq("t6_reads", n_rd, 5);
    check_eq("t6_nbytes", n_got, 1);
    check_eq("t6_byte0", got[0], 8'hAA);
    check_eq("t6_len", last_len, 1);
    check_eq("t6_perr", last_perr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
